// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: outcome, redirect/flush, flag consumption and statistics.
// Define BRU_PREDICT_EN to include the 2-bit saturating predictor table read by fetch.
module branch_resolve_unit #(
  parameter int unsigned FLAG_W    = 4,
  parameter int unsigned PC_W      = 16,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned SEL_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  // Fetch-side lookup
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              pred_taken,
  // Resolve stage
  input  logic [FLAG_W-1:0] flags,
  input  logic              br_valid,
  input  logic              br_uncond,
  input  logic [SEL_W-1:0]  br_sel,
  input  logic [PC_W-1:0]   br_pc,
  input  logic [PC_W-1:0]   br_target,
  input  logic              br_pred,
  input  logic              stall,
  // Resolution results
  output logic              jump_taken,
  output logic              redirect,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              if_flush,
  output logic              id_flush,
  output logic [FLAG_W-1:0] flag_clr,
  // Statistics
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int unsigned IdxW = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

  logic            active;
  logic            flag_bit;
  logic            taken;
  logic            mispred;
  logic [PC_W-1:0] pc_inc;

  // ---------------------------------------------------------------------------
  // Outcome and redirect
  // ---------------------------------------------------------------------------
  assign active   = br_valid & ~stall;
  assign flag_bit = flags[br_sel];
  assign taken    = br_uncond | flag_bit;

  assign jump_taken = active & taken;
  assign mispred    = active & (taken != br_pred);

  assign redirect = mispred;
  assign if_flush = mispred;
  assign id_flush = mispred;

  // Fall-through wraps at the top of the PC space.
  assign pc_inc      = br_pc + PC_W'(1);
  assign redirect_pc = taken ? br_target : pc_inc;

  // Only a taken conditional branch consumes the flag it tested.
  always_comb begin
    flag_clr = '0;
    if (active && !br_uncond && taken) begin
      flag_clr[br_sel] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating statistics
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    br_cnt_d      = br_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (active && (br_cnt_q != {CNT_W{1'b1}})) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    if (mispred && (mispred_cnt_q != {CNT_W{1'b1}})) begin
      mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      br_cnt_q      <= br_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign br_cnt      = br_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  // fetch_pc upper bits never index the table.
  logic unused_fetch_pc;
  assign unused_fetch_pc = ^fetch_pc;

  // ---------------------------------------------------------------------------
  // Branch history table
  // ---------------------------------------------------------------------------
`ifdef BRU_PREDICT_EN
  logic [1:0]      bht_q [BHT_DEPTH];
  logic [IdxW-1:0] upd_idx;
  logic [IdxW-1:0] fetch_idx;
  logic [1:0]      upd_old;
  logic [1:0]      upd_new;

  assign upd_idx   = br_pc[IdxW-1:0];
  assign fetch_idx = fetch_pc[IdxW-1:0];
  assign upd_old   = bht_q[upd_idx];

  always_comb begin
    upd_new = upd_old;
    if (taken) begin
      if (upd_old != 2'b11) begin
        upd_new = upd_old + 2'd1;
      end
    end else begin
      if (upd_old != 2'b00) begin
        upd_new = upd_old - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (active) begin
      bht_q[upd_idx] <= upd_new;
    end
  end

  // Reads the pre-update entry; a same-cycle update shows up next cycle.
  assign pred_taken = bht_q[fetch_idx][1];
`else
  // Static not-taken: fetch never predicts taken.
  assign pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; expectations adapt to BRU_PREDICT_EN.
module tb_branch_resolve_unit;

`ifdef BRU_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif
  localparam int unsigned CntMax = 15;

  logic        clk;
  logic        rst_n;
  logic [15:0] fetch_pc;
  logic        pred_taken;
  logic [3:0]  flags;
  logic        br_valid;
  logic        br_uncond;
  logic [1:0]  br_sel;
  logic [15:0] br_pc;
  logic [15:0] br_target;
  logic        br_pred;
  logic        stall;
  logic        jump_taken;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        if_flush;
  logic        id_flush;
  logic [3:0]  flag_clr;
  logic [3:0]  br_cnt;
  logic [3:0]  mispred_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_br   = 0;
  int exp_mp   = 0;

  branch_resolve_unit #(
    .FLAG_W   (4),
    .PC_W     (16),
    .BHT_DEPTH(16),
    .CNT_W    (4),
    .SEL_W    (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_pc   (fetch_pc),
    .pred_taken (pred_taken),
    .flags      (flags),
    .br_valid   (br_valid),
    .br_uncond  (br_uncond),
    .br_sel     (br_sel),
    .br_pc      (br_pc),
    .br_target  (br_target),
    .br_pred    (br_pred),
    .stall      (stall),
    .jump_taken (jump_taken),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_flush   (if_flush),
    .id_flush   (id_flush),
    .flag_clr   (flag_clr),
    .br_cnt     (br_cnt),
    .mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic unc, input logic [1:0] sel, input logic [15:0] pc,
                       input logic [15:0] tgt, input logic pr, input logic [3:0] fl);
    br_valid  = 1'b1;
    stall     = 1'b0;
    br_uncond = unc;
    br_sel    = sel;
    br_pc     = pc;
    br_target = tgt;
    br_pred   = pr;
    flags     = fl;
  endtask

  task automatic idle();
    br_valid = 1'b0;
    stall    = 1'b0;
  endtask

  // Expected statistics after one active resolution.
  task automatic upd(input bit mis);
    if (exp_br < CntMax) exp_br++;
    if (mis && exp_mp < CntMax) exp_mp++;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_br_cnt"}, 32'(br_cnt), 32'(exp_br));
    chk({tag, "_mispred_cnt"}, 32'(mispred_cnt), 32'(exp_mp));
  endtask

  initial begin
    rst_n    = 1'b0;
    fetch_pc = 16'h0003;
    idle();
    br_uncond = 1'b0;
    br_sel    = 2'd0;
    br_pc     = 16'h0;
    br_target = 16'h0;
    br_pred   = 1'b0;
    flags     = 4'h0;

    // Reset state
    #3;
    chk("rst_br_cnt", 32'(br_cnt), 32'h0);
    chk("rst_mispred_cnt", 32'(mispred_cnt), 32'h0);
    chk("rst_pred", 32'(pred_taken), 32'h0);
    chk("rst_redirect", 32'(redirect), 32'h0);
    chk("rst_flag_clr", 32'(flag_clr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First taken conditional, predicted not-taken
    @(negedge clk);
    drive(1'b0, 2'd0, 16'h0003, 16'h0100, 1'b0, 4'b0001);
    #1;
    chk("a_jump", 32'(jump_taken), 32'h1);
    chk("a_redirect", 32'(redirect), 32'h1);
    chk("a_rpc", 32'(redirect_pc), 32'h0100);
    chk("a_if_flush", 32'(if_flush), 32'h1);
    chk("a_id_flush", 32'(id_flush), 32'h1);
    chk("a_flag_clr", 32'(flag_clr), 32'h1);
    chk("a_pred_pre", 32'(pred_taken), 32'h0);
    upd(1'b1);
    @(negedge clk);
    idle();
    #1;
    chk_cnt("a");
    chk("a_pred_post", 32'(pred_taken), 32'(PRED));

    // Three more taken: entry saturates at 11
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 2'd0, 16'h0003, 16'h0100, PRED, 4'b0001);
      #1;
      chk("sat_redirect", 32'(redirect), 32'(!PRED));
      upd(!PRED);
    end
    @(negedge clk);
    idle();
    #1;
    chk_cnt("sat");
    chk("sat_pred", 32'(pred_taken), 32'(PRED));

    // Not-taken after saturation: falls through to 0x0004, entry 10
    @(negedge clk);
    drive(1'b0, 2'd0, 16'h0003, 16'h0100, PRED, 4'b0000);
    #1;
    chk("nt_jump", 32'(jump_taken), 32'h0);
    chk("nt_redirect", 32'(redirect), 32'(PRED));
    chk("nt_rpc", 32'(redirect_pc), 32'h0004);
    chk("nt_flag_clr", 32'(flag_clr), 32'h0);
    upd(PRED);
    @(negedge clk);
    idle();
    #1;
    chk_cnt("nt");
    chk("nt_pred", 32'(pred_taken), 32'(PRED));

    // Unconditional jump: ignores flags, never clears the selected flag
    @(negedge clk);
    drive(1'b1, 2'd2, 16'h0005, 16'h0200, 1'b1, 4'b0100);
    #1;
    chk("unc_jump", 32'(jump_taken), 32'h1);
    chk("unc_redirect", 32'(redirect), 32'h0);
    chk("unc_if_flush", 32'(if_flush), 32'h0);
    chk("unc_flag_clr", 32'(flag_clr), 32'h0);
    upd(1'b0);
    @(negedge clk);
    idle();
    #1;
    chk_cnt("unc");

    // Stalled for three cycles, then resolves once
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 2'd1, 16'h0006, 16'h0300, 1'b0, 4'b0010);
      stall = 1'b1;
      #1;
      chk("stl_jump", 32'(jump_taken), 32'h0);
      chk("stl_redirect", 32'(redirect), 32'h0);
      chk("stl_flag_clr", 32'(flag_clr), 32'h0);
      chk("stl_br_cnt", 32'(br_cnt), 32'(exp_br));
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    chk("stl_go_flag_clr", 32'(flag_clr), 32'b0010);
    chk("stl_go_redirect", 32'(redirect), 32'h1);
    chk("stl_go_rpc", 32'(redirect_pc), 32'h0300);
    upd(1'b1);
    @(negedge clk);
    idle();
    #1;
    chk_cnt("stl");

    // Fall-through wraps from 0xFFFF to 0x0000
    @(negedge clk);
    drive(1'b0, 2'd3, 16'hFFFF, 16'h1234, 1'b1, 4'b0000);
    #1;
    chk("wrap_rpc", 32'(redirect_pc), 32'h0000);
    chk("wrap_redirect", 32'(redirect), 32'h1);
    upd(1'b1);
    @(negedge clk);
    idle();
    #1;
    chk_cnt("wrap");

    // Drive both counters into saturation, then one more mispredict
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(1'b0, 2'd3, 16'hFFFF, 16'h1234, 1'b1, 4'b0000);
      upd(1'b1);
    end
    @(negedge clk);
    idle();
    #1;
    chk("cnt_sat_br", 32'(br_cnt), 32'hF);
    chk("cnt_sat_mp", 32'(mispred_cnt), 32'hF);
    @(negedge clk);
    drive(1'b0, 2'd3, 16'hFFFF, 16'h1234, 1'b1, 4'b0000);
    upd(1'b1);
    @(negedge clk);
    idle();
    #1;
    chk("cnt_hold_br", 32'(br_cnt), 32'hF);
    chk("cnt_hold_mp", 32'(mispred_cnt), 32'hF);

    // Asynchronous reset in the middle of a resolve cycle
    @(negedge clk);
    fetch_pc = 16'h0003;
    drive(1'b0, 2'd0, 16'h0003, 16'h0100, 1'b0, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_br_cnt", 32'(br_cnt), 32'h0);
    chk("mrst_mp_cnt", 32'(mispred_cnt), 32'h0);
    chk("mrst_pred3", 32'(pred_taken), 32'h0);
    chk("mrst_jump", 32'(jump_taken), 32'h1);
    fetch_pc = 16'h0005;
    #1;
    chk("mrst_pred5", 32'(pred_taken), 32'h0);
    idle();
    exp_br = 0;
    exp_mp = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // First resolution after reset updates normally
    @(negedge clk);
    fetch_pc = 16'h0003;
    drive(1'b0, 2'd0, 16'h0003, 16'h0100, 1'b0, 4'b0001);
    #1;
    chk("post_redirect", 32'(redirect), 32'h1);
    upd(1'b1);
    @(negedge clk);
    idle();
    #1;
    chk_cnt("post");
    chk("post_pred", 32'(pred_taken), 32'(PRED));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

- Resolves conditional and unconditional branches in the execute stage.
- Trains a per-PC table of 2-bit saturating predictors, which the fetch stage reads.
- When a resolved outcome disagrees with the fetch prediction, it issues a redirect plus IF/ID flush; it also clears the consumed condition flag on a taken conditional branch and keeps saturating branch and mispredict statistics.
- Sits between the flag register/ALU, the fetch PC mux and the IF/ID and ID/EX pipeline registers.
- Successor to the combinational jump decision unit: parametrised flag count, table depth and PC width.

## Interface
- FLAG_W, default 4: number of condition flags.
- PC_W, default 16: PC width in words.
- BHT_DEPTH, default 16: predictor entries, power of two ≥ 2; IDX_W = log2(BHT_DEPTH).
- CNT_W, default 16: statistics counter width.
- SEL_W, default 2: flag-select width; must equal log2(FLAG_W).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_pc  in  PC_W  PC being fetched; predictor lookup.
- pred_taken  out  1  prediction for fetch_pc.
- flags  in  FLAG_W  current condition flags.
- br_valid  in  1  branch present in resolve stage.
- br_uncond  in  1  unconditional jump; ignores flags.
- br_sel  in  SEL_W  index of the flag tested by a conditional branch.
- br_pc  in  PC_W  PC of the resolving branch.
- br_target  in  PC_W  taken target.
- br_pred  in  1  prediction carried down from fetch for this branch.
- stall  in  1  resolve stage held; branch not yet resolvable.
- jump_taken  out  1  actual outcome.
- redirect  out  1  fetch must load redirect_pc.
- redirect_pc  out  PC_W  corrected PC.
- if_flush, id_flush  out  1  squash IF/ID and ID/EX contents.
- flag_clr  out  FLAG_W  one-hot clear of the consumed flag.
- br_cnt, mispred_cnt  out  CNT_W  statistics.

## Operation
- Resolve is active when br_valid=1 and stall=0; all of the following are gated by it.
- Outcome:
  - taken = br_uncond | flags[br_sel].
  - jump_taken = active & taken.
- Mispredict: mispred = active & (taken != br_pred).
  - redirect = if_flush = id_flush = mispred.
  - redirect_pc = taken ? br_target : br_pc + 1, modulo 2^PC_W (0xFFFF+1 → 0x0000).
  - Correct prediction: no redirect, no flush.
- Flag consumption: flag_clr = (active & ~br_uncond & taken) ? (1 << br_sel) : 0. Flags are never cleared by an unconditional jump or a not-taken branch.
- Predictor table (BHT): BHT_DEPTH entries of 2 bits.
  - Index = pc[IDX_W-1:0].
  - pred_taken = entry[fetch_pc index][1].
  - Update on active: taken increments, saturating at 2'b11; not-taken decrements, saturating at 2'b00.
  - All branches train, unconditional included.
- Statistics:
  - br_cnt increments on every active cycle.
  - mispred_cnt increments on every mispred.
  - Both saturate at all-ones and never wrap.
- Inactive cycle (br_valid=0 or stall=1): redirect, flushes, jump_taken and flag_clr are 0; no table or counter change.
- Out-of-range br_sel cannot occur, since SEL_W = log2(FLAG_W).

## Timing
- jump_taken, redirect, redirect_pc, if_flush, id_flush and flag_clr are combinational: valid in the resolve cycle, zero latency.
- The consumer registers them at the next rising edge.
- BHT entry and statistics update at the rising edge that ends the active cycle.
- pred_taken is combinational from fetch_pc and the current table.
- Same-index lookup and update in one cycle: pred_taken returns the pre-update value; the new value is visible the following cycle.
- Back-to-back active cycles on the same index apply sequential updates with no lost increment (e.g. 01 → 10 → 11).
- Reset (async, rst_n=0, any time including mid-resolve):
  - all BHT entries = 2'b01 (weakly not-taken);
  - br_cnt = mispred_cnt = 0.
  - Combinational outputs remain pure functions of inputs; the pipeline holds br_valid=0 during reset.
- Release of rst_n is synchronised externally; the first active edge after release updates normally.

## Configuration
- BRU_PREDICT_EN defined: BHT present as described.
- Undefined:
  - no table storage; pred_taken tied 0;
  - the unit behaves as static not-taken, so every taken branch redirects and flushes;
  - not-taken branches never flush, because fetch never predicts taken, so br_pred=0;
  - statistics unchanged.

## Test plan
- Reset, then fetch_pc=0x0003 → pred_taken=0. Resolve br_pc=0x0003, br_pred=0, taken (br_sel=0, flags=4'b0001) → redirect=1, redirect_pc=br_target, if_flush=id_flush=1, flag_clr=4'b0001, br_cnt=1, mispred_cnt=1. Next cycle pred_taken=1 (entry 10).
- Same branch resolved taken three times → entry saturates at 11. Then one not-taken with br_pred=1 → redirect_pc=0x0004, entry 10, pred still 1.
- br_uncond=1, flags=0, br_pred=1 → jump_taken=1, no flush, flag_clr=0, mispred_cnt unchanged.
- br_valid=1 with stall=1 for 3 cycles, then stall=0 → exactly one resolution; br_cnt +1 only.
- br_pc=0xFFFF, not taken, br_pred=1 → redirect_pc=0x0000. Preload mispred_cnt near all-ones; further mispredicts hold at all-ones.
- Assert rst_n=0 mid-sequence → all entries 01, counters 0 asynchronously. Under BRU_PREDICT_EN undefined, pred_taken stays 0 and every taken branch flushes.
